// File: rtl/isa_pkg.sv
// Shared ISA bus definitions: widths, op encodings and host-master state codes.
// Small helpers decode an op into its strobe pattern and its read/write direction.
package isa_pkg;

    localparam int ISA_AW = 20;
    localparam int ISA_DW = 8;

    localparam logic [1:0] ISA_OP_MEMR = 2'b00;
    localparam logic [1:0] ISA_OP_MEMW = 2'b01;
    localparam logic [1:0] ISA_OP_IOR  = 2'b10;
    localparam logic [1:0] ISA_OP_IOW  = 2'b11;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_STROBE = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    // Active-low strobe vector ordered {memr, memw, ior, iow}.
    function automatic logic [3:0] strobe_for_op(input logic [1:0] op);
        logic [3:0] s;
        s = 4'hF;
        unique case (op)
            ISA_OP_MEMR: s = 4'b0111;
            ISA_OP_MEMW: s = 4'b1011;
            ISA_OP_IOR:  s = 4'b1101;
            ISA_OP_IOW:  s = 4'b1110;
        endcase
        return s;
    endfunction

    function automatic logic op_is_read(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/isa_host_master.sv
// ISA bus initiator: one 8-bit memory/I/O cycle per request, with programmable
// setup, strobe and hold lengths and a single-cycle response pulse.
module isa_host_master
    import isa_pkg::*;
#(
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 8,
    parameter int HOLD_CYCLES   = 2
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [19:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_dir_err,
    output logic [19:0] bus_a,
    output logic [7:0]  bus_d,
    output logic        bus_memr_l,
    output logic        bus_memw_l,
    output logic        bus_ior_l,
    output logic        bus_iow_l,
    output logic        bus_aen,
    input  logic [7:0]  bus_in,
    input  logic        bus_dir
);

    localparam logic [7:0] SETUP_LOAD  = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] STROBE_LOAD = 8'(STROBE_CYCLES - 1);
    localparam logic [7:0] HOLD_LOAD   = 8'(HOLD_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [19:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  cap_q, cap_d;
    logic        dir_seen_q, dir_seen_d;
    logic        ready_q, ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic        rsp_dir_err_q, rsp_dir_err_d;
    logic [19:0] bus_a_q, bus_a_d;
    logic [7:0]  bus_d_q, bus_d_d;
    logic [3:0]  strobe_q, strobe_d;
    logic        aen_q, aen_d;
    logic        busy_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        cap_d         = cap_q;
        dir_seen_d    = dir_seen_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_dir_err_d = rsp_dir_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    op_d       = req_op;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    dir_seen_d = 1'b0;
                    cnt_d      = SETUP_LOAD;
                    state_d    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == 8'd0) begin
                    cnt_d   = STROBE_LOAD;
                    state_d = ST_STROBE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_STROBE: begin
                // Last strobe cycle's sample wins; bus_dir is remembered if ever seen.
                if (op_is_read(op_q)) begin
                    cap_d      = bus_in;
                    dir_seen_d = dir_seen_q | bus_dir;
                end
                if (cnt_q == 8'd0) begin
                    cnt_d   = HOLD_LOAD;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 8'd0) begin
                    state_d       = ST_RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = op_is_read(op_q) ? cap_q : 8'h00;
                    rsp_dir_err_d = op_is_read(op_q) ? ~dir_seen_q : dir_seen_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus pins are registered from the next state so they leave the flops glitch-free.
    always_comb begin
        busy_d   = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
        ready_d  = (state_d == ST_IDLE);
        aen_d    = ~busy_d;
        bus_a_d  = busy_d ? addr_d : 20'h0;
        bus_d_d  = (busy_d && !op_is_read(op_d)) ? wdata_d : 8'h00;
        strobe_d = (state_d == ST_STROBE) ? strobe_for_op(op_d) : 4'hF;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset_l) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 8'd0;
            op_q          <= ISA_OP_MEMR;
            addr_q        <= 20'h0;
            wdata_q       <= 8'h00;
            cap_q         <= 8'h00;
            dir_seen_q    <= 1'b0;
            ready_q       <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 8'h00;
            rsp_dir_err_q <= 1'b0;
            bus_a_q       <= 20'h0;
            bus_d_q       <= 8'h00;
            strobe_q      <= 4'hF;
            aen_q         <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_q          <= op_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            cap_q         <= cap_d;
            dir_seen_q    <= dir_seen_d;
            ready_q       <= ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_dir_err_q <= rsp_dir_err_d;
            bus_a_q       <= bus_a_d;
            bus_d_q       <= bus_d_d;
            strobe_q      <= strobe_d;
            aen_q         <= aen_d;
        end
    end

    assign req_ready   = ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_dir_err = rsp_dir_err_q;
    assign bus_a       = bus_a_q;
    assign bus_d       = bus_d_q;
    assign bus_memr_l  = strobe_q[3];
    assign bus_memw_l  = strobe_q[2];
    assign bus_ior_l   = strobe_q[1];
    assign bus_iow_l   = strobe_q[0];
    assign bus_aen     = aen_q;

endmodule

// File: tb/tb_isa_host_master.sv
// Bench for isa_host_master: a cycle-offset model checks every output each cycle,
// and directed scenarios pin latency, strobe width, read data and dir errors.
module tb_isa_host_master;

    localparam int S = 2;
    localparam int T = 8;
    localparam int H = 2;
    localparam int L = S + T + H;

    logic        clk = 1'b0;
    logic        reset_l = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [19:0] req_addr = 20'h0;
    logic [7:0]  req_wdata = 8'h00;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_dir_err;
    logic [19:0] bus_a;
    logic [7:0]  bus_d;
    logic        bus_memr_l, bus_memw_l, bus_ior_l, bus_iow_l, bus_aen;
    logic [7:0]  bus_in;
    logic        bus_dir;

    logic [7:0]  tgt_data = 8'h00;
    logic        tgt_dir_en = 1'b1;

    // Second build with short phases
    logic        s_req_valid = 1'b0;
    logic        s_req_ready, s_rsp_valid, s_rsp_dir_err;
    logic [7:0]  s_rsp_rdata, s_bus_d;
    logic [19:0] s_bus_a;
    logic        s_memr_l, s_memw_l, s_ior_l, s_iow_l, s_aen;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rsp_cnt = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (rsp_valid === 1'b1) rsp_cnt <= rsp_cnt + 1;

    // Simple target: drives data while any read strobe is low.
    assign bus_in  = (!bus_memr_l || !bus_ior_l) ? tgt_data : 8'h00;
    assign bus_dir = (!bus_memr_l || !bus_ior_l) && tgt_dir_en;

    isa_host_master dut (
        .clk(clk), .reset_l(reset_l),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_dir_err(rsp_dir_err),
        .bus_a(bus_a), .bus_d(bus_d),
        .bus_memr_l(bus_memr_l), .bus_memw_l(bus_memw_l),
        .bus_ior_l(bus_ior_l), .bus_iow_l(bus_iow_l), .bus_aen(bus_aen),
        .bus_in(bus_in), .bus_dir(bus_dir)
    );

    isa_host_master #(.SETUP_CYCLES(1), .STROBE_CYCLES(3), .HOLD_CYCLES(1)) dut_s (
        .clk(clk), .reset_l(reset_l),
        .req_valid(s_req_valid), .req_ready(s_req_ready), .req_op(2'b00),
        .req_addr(20'hC0000), .req_wdata(8'h00),
        .rsp_valid(s_rsp_valid), .rsp_rdata(s_rsp_rdata), .rsp_dir_err(s_rsp_dir_err),
        .bus_a(s_bus_a), .bus_d(s_bus_d),
        .bus_memr_l(s_memr_l), .bus_memw_l(s_memw_l),
        .bus_ior_l(s_ior_l), .bus_iow_l(s_iow_l), .bus_aen(s_aen),
        .bus_in(8'h5A), .bus_dir(1'b1)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model: age counts clocks since the accept edge; the phase follows from age alone.
    int          m_age = 0;
    logic [1:0]  m_op = 2'b00;
    logic [19:0] m_addr = 20'h0;
    logic [7:0]  m_wd = 8'h00;
    logic [7:0]  m_cap = 8'h00;
    logic        m_seen = 1'b0;
    logic        e_ready = 1'b0, e_rv = 1'b0, e_err = 1'b0;
    logic [7:0]  e_rd = 8'h00;

    always @(posedge clk) begin : model
        int a;
        logic [7:0] cap;
        logic seen;
        if (!reset_l) begin
            m_age <= 0; e_ready <= 1'b0; e_rv <= 1'b0; e_rd <= 8'h00; e_err <= 1'b0;
        end else begin
            a = m_age; cap = m_cap; seen = m_seen;
            if (a == 0) begin
                if (req_valid && e_ready) begin
                    a = 1; seen = 1'b0;
                    m_op <= req_op; m_addr <= req_addr; m_wd <= req_wdata;
                end
            end else if (a == L + 1) begin
                a = 0;
            end else begin
                if (a > S && a <= S + T && !m_op[0]) begin
                    cap = bus_in;
                    seen = seen | bus_dir;
                end
                a++;
            end
            m_age <= a; m_cap <= cap; m_seen <= seen;
            e_ready <= (a == 0);
            e_rv <= (a == L + 1);
            if (a == L + 1) begin
                e_rd  <= m_op[0] ? 8'h00 : cap;
                e_err <= m_op[0] ? seen : !seen;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic busy;
        logic [3:0] strb;
        logic [43:0] exp_v, got_v;
        if (cmp_en) begin
            busy = (m_age >= 1) && (m_age <= L);
            strb = 4'hF;
            if (busy && m_age > S && m_age <= S + T) begin
                case (m_op)
                    2'b00: strb = 4'b0111;
                    2'b01: strb = 4'b1011;
                    2'b10: strb = 4'b1101;
                    default: strb = 4'b1110;
                endcase
            end
            exp_v = {e_ready, e_rv, e_rd, e_err, strb, ~busy,
                     busy ? m_addr : 20'h0, (busy && m_op[0]) ? m_wd : 8'h00};
            got_v = {req_ready, rsp_valid, rsp_rdata, rsp_dir_err,
                     bus_memr_l, bus_memw_l, bus_ior_l, bus_iow_l, bus_aen, bus_a, bus_d};
            check("cycle_model", {20'h0, got_v}, {20'h0, exp_v});
        end
    end

    // Issue one request starting at a negedge; returns latency, strobe-low cycle count and response.
    task automatic run_req(input logic [1:0] op, input logic [19:0] addr, input logic [7:0] wd,
                           output int lat, output int slow, output logic [7:0] rd, output logic err);
        int n;
        lat = -1; slow = 0; rd = 8'h00; err = 1'b0;
        req_op = op; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            check("ready_timeout", 64'd0, 64'd1);
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 1; i < 40; i++) begin
            if (!(bus_memr_l && bus_memw_l && bus_ior_l && bus_iow_l)) slow++;
            if (rsp_valid === 1'b1) begin
                lat = i; rd = rsp_rdata; err = rsp_dir_err;
                break;
            end
            @(negedge clk);
        end
        if (lat < 0) check("rsp_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int lat, slow, n, base;
        int acc[3];
        logic [7:0] rd;
        logic err;

        @(posedge clk);
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {req_ready, rsp_valid, bus_memr_l, bus_memw_l, bus_ior_l, bus_iow_l, bus_aen, bus_a, bus_d},
              {1'b0, 1'b0, 4'hF, 1'b1, 20'h0, 8'h00});
        reset_l = 1'b1;
        @(negedge clk);

        run_req(2'b01, 20'hB0000, 8'h41, lat, slow, rd, err);
        check("memw_latency", lat, 13);
        check("memw_strobe_len", slow, 8);
        check("memw_rdata_dir", {rd, err}, {8'h00, 1'b0});

        tgt_data = 8'h41; tgt_dir_en = 1'b1;
        run_req(2'b00, 20'hB0000, 8'h00, lat, slow, rd, err);
        check("memr_rdata", rd, 8'h41);
        check("memr_dir_ok", err, 1'b0);

        tgt_dir_en = 1'b0;
        run_req(2'b00, 20'hB0000, 8'h00, lat, slow, rd, err);
        check("memr_dir_err", err, 1'b1);
        tgt_dir_en = 1'b1;

        run_req(2'b11, 20'h003B8, 8'h08, lat, slow, rd, err);
        check("iow_strobe_len", slow, 8);
        check("iow_rdata_dir", {rd, err}, {8'h00, 1'b0});
        tgt_data = 8'hF1;
        run_req(2'b10, 20'h003BA, 8'h00, lat, slow, rd, err);
        check("ior_rdata", rd, 8'hF1);
        check("ior_latency", lat, 13);

        // Three requests with req_valid held throughout
        @(negedge clk);
        base = rsp_cnt;
        req_op = 2'b11; req_addr = 20'h00300; req_wdata = 8'h10; req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (req_ready !== 1'b1 && n < 60) begin
                @(negedge clk);
                n++;
            end
            if (n >= 60) check("b2b_ready_timeout", 64'd0, 64'd1);
            acc[k] = cyc;
            @(negedge clk);
            req_addr = req_addr + 20'h1; req_wdata = req_wdata + 8'h1;
            if (k == 2) req_valid = 1'b0;
        end
        repeat (16) @(negedge clk);
        check("b2b_spacing_1", acc[1] - acc[0], 14);
        check("b2b_spacing_2", acc[2] - acc[1], 14);
        check("b2b_rsp_count", rsp_cnt - base, 3);

        // Reset on the 4th strobe cycle of a memory read
        tgt_data = 8'h77;
        req_op = 2'b00; req_addr = 20'hB0010; req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) check("rst_ready_timeout", 64'd0, 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        base = rsp_cnt;
        repeat (5) @(negedge clk);
        check("rst_pre_strobe", bus_memr_l, 1'b0);
        reset_l = 1'b0;
        @(negedge clk);
        check("rst_abort_bus",
              {bus_memr_l, bus_memw_l, bus_ior_l, bus_iow_l, bus_aen, rsp_valid},
              {4'hF, 1'b1, 1'b0});
        reset_l = 1'b1;
        repeat (16) @(negedge clk);
        check("rst_no_rsp", rsp_cnt - base, 0);
        tgt_data = 8'h3C;
        run_req(2'b00, 20'hB0020, 8'h00, lat, slow, rd, err);
        check("post_rst_req", {lat[7:0], rd, err}, {8'd13, 8'h3C, 1'b0});

        // Short-phase build: 1/3/1
        @(negedge clk);
        s_req_valid = 1'b1;
        n = 0;
        while (s_req_ready !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) check("short_ready_timeout", 64'd0, 64'd1);
        @(negedge clk);
        s_req_valid = 1'b0;
        lat = -1; slow = 0;
        for (int i = 1; i < 20; i++) begin
            if (!s_memr_l) slow++;
            if (s_rsp_valid === 1'b1) begin
                lat = i; rd = s_rsp_rdata; err = s_rsp_dir_err;
                break;
            end
            @(negedge clk);
        end
        check("short_latency", lat, 6);
        check("short_strobe_len", slow, 3);
        check("short_rdata_dir", {rd, err}, {8'h5A, 1'b0});

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
